uart_rx_queue: RTL
==================

# uart_rx_queue

Receive-side controller that sits between the UART `receiver` and any byte consumer. It sequences the receiver's level-style `rdy`/`data` outputs into single-shot byte captures, buffers them in a small FIFO, and presents a valid/ready stream downstream. It also reports overrun and, optionally, line-idle gaps for framing.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `IDLE_CYCLES`, 32: cycles without a capture before `idle` asserts; ≥1. Used only with the idle feature.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_rdy`  in  1  receiver `rdy`: high from byte completion until the next start bit.
- `rx_data`  in  8  receiver `data`: stable while `rx_rdy` is high, shifting otherwise.
- `m_valid`  out  1  head byte available.
- `m_data`  out  8  head byte.
- `m_ready`  in  1  consumer accepts the head byte when `m_valid` is also high.
- `level`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overrun`  out  1  sticky: a byte was dropped.
- `clr_overrun`  in  1  clears `overrun`.
- `idle`  out  1  line-idle indicator; present only with `UART_RXQ_IDLE_EN`.

## Operation
- Edge detect: `rdy_q` registers `rx_rdy` every cycle. `cap = rx_rdy & ~rdy_q`.
- `rdy_q` resets to 1. A receiver still holding `rdy` high through reset therefore produces no capture until it clears and rises again.
- One `cap` is one push of `rx_data`. A `rx_rdy` held high for any length pushes exactly once.
- Pop: `pop = m_valid & m_ready`. The head advances and `level` decrements.
- Simultaneous `cap` and `pop`:
  - When not empty, both take effect and `level` is unchanged.
  - When empty, `m_valid` is 0, so no pop occurs and only the push happens.
- Full with `cap` and no `pop`: the byte is dropped, FIFO contents are unchanged, and `overrun` is set.
- Full with `cap` and `pop` in the same cycle: the byte is accepted and no overrun occurs.
- `overrun` clears on `clr_overrun`. If a drop and `clr_overrun` happen in the same cycle, set wins.
- `m_valid = (level != 0)`. `m_data` is the head entry, read combinationally from FIFO storage.
- `m_data` is held stable while `m_valid` is high and `m_ready` is low.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `level` distinguishes full from empty.
- Reset values:
  - `level` = 0, `m_valid` = 0, `m_data` = 0 (storage cleared).
  - `overrun` = 0, `rdy_q` = 1.
  - `idle` = 1 and idle counter = IDLE_CYCLES.
- Reset asserted mid-operation discards all queued bytes immediately (asynchronous).

## Timing
- Capture latency: `rx_rdy` is sampled 0 at edge k-1 and 1 at edge k, so `cap` is true at edge k. After edge k, `m_valid` = 1 and `m_data` = `rx_data` as sampled at edge k.
- Pop: with `m_valid` & `m_ready` at edge k, the next entry (or `m_valid` = 0) is visible after edge k.
- Throughput: one push and one pop per cycle. The UART byte rate is far lower than this.
- Idle counter (feature on):
  - `cap` at edge k sets the counter to 0 and `idle` = 0 after edge k.
  - Otherwise the counter increments and saturates at IDLE_CYCLES.
  - `idle` = 1 once the counter equals IDLE_CYCLES, i.e. after IDLE_CYCLES cycles with no `cap`.

## Configuration
- `UART_RXQ_IDLE_EN` defined: the idle counter and the `idle` port are built as described above.
- `UART_RXQ_IDLE_EN` undefined: the `idle` port and the counter are absent, and `IDLE_CYCLES` is unused. All other behaviour is identical.

## Structure
- Package `uart_rxq_pkg`:
  - Byte width constant `UART_BYTE_W` = 8.
  - Default `DEPTH` and `IDLE_CYCLES` constants.
  - `typedef logic [UART_BYTE_W-1:0] uart_byte_t`.
- One sub-module, `uart_rxq_fifo`:
  - Parameterized sync FIFO with async reset, push/pop/full/empty/level, and combinational head read.
- The top holds the edge detector, overrun logic and idle counter.

## Test plan
- Single byte: hold `rx_data` = 0xE0 and raise `rx_rdy` for 10 cycles, with `m_ready` = 0. Required: `level` = 1 (not 10), `m_valid` = 1 one edge after rise, `m_data` = 0xE0.
- Ordering: push 0x01, 0x07, 0x1C, 0xE0 (rdy pulses with gaps), then `m_ready` = 1. Required: pops in that order, one per cycle, then `m_valid` = 0 and `level` = 0.
- Overrun: DEPTH = 4, push 5 bytes with `m_ready` = 0. Required: 5th dropped, `overrun` = 1, first 4 intact. Assert `clr_overrun`: `overrun` = 0 next cycle.
- Full boundary: at full, push 0xAA in the same cycle as a pop. Required: no overrun, `level` stays 4, 0xAA is last out.
- Reset: `rst_n` = 0 mid-stream with `rx_rdy` = 1 and 3 bytes queued. Required: immediately `level` = 0, `m_valid` = 0. After release with `rx_rdy` still 1, no capture occurs until `rx_rdy` falls and rises again.
- Idle (`UART_RXQ_IDLE_EN`, IDLE_CYCLES = 8): capture one byte. Required: `idle` = 0 the next cycle, `idle` = 1 exactly 8 cycles later. A capture at cycle 5 restarts the count.

Source files
------------

// File: rtl/uart_rxq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rxq_pkg
//  Brief   : Shared constants and byte type for the UART receive queue.
//  Rev     : 1.0  initial release
// ============================================================================
package uart_rxq_pkg;

    localparam int UART_BYTE_W         = 8;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_IDLE_CYCLES = 32;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage
`default_nettype wire

// File: rtl/uart_rxq_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rxq_fifo
//  Brief   : Synchronous byte FIFO, async reset, combinational head read.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rxq_fifo
    import uart_rxq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  uart_byte_t   wr_data,
    input  logic         pop,
    output uart_byte_t   rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [AW:0]   c_lvl_one  = (AW+1)'(1);
    localparam logic [AW:0]   c_lvl_full = (AW+1)'(DEPTH);

    uart_byte_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign full    = (r_level == c_lvl_full);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_queue.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_queue
//  Brief   : Edge-captures receiver bytes into a FIFO with valid/ready output,
//            sticky overrun, and optional idle detect (UART_RXQ_IDLE_EN).
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rx_queue
    import uart_rxq_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_rdy,
    input  uart_byte_t               rx_data,
    output logic                     m_valid,
    output uart_byte_t               m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     clr_overrun
`ifdef UART_RXQ_IDLE_EN
    ,
    output logic                     idle
`endif
);

    logic r_rdy_q;
    logic r_overrun;
    logic w_cap;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    // Resetting to 1 suppresses a capture from a rdy held high across reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy_q <= 1'b1;
        else        r_rdy_q <= rx_rdy;
    end

    assign w_cap   = rx_rdy & ~r_rdy_q;
    assign m_valid = ~w_empty;
    assign w_pop   = m_valid & m_ready;
    assign w_drop  = w_cap & w_full & ~w_pop;

    uart_rxq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_cap),
        .wr_data (rx_data),
        .pop     (w_pop),
        .rd_data (m_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_overrun <= 1'b0;
        else if (w_drop)      r_overrun <= 1'b1;
        else if (clr_overrun) r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;

`ifdef UART_RXQ_IDLE_EN
    localparam int            CW         = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] c_idle_max = CW'(IDLE_CYCLES);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [CW-1:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_idle_cnt <= c_idle_max;
        else if (w_cap)                   r_idle_cnt <= '0;
        else if (r_idle_cnt != c_idle_max) r_idle_cnt <= r_idle_cnt + c_cnt_one;
    end

    assign idle = (r_idle_cnt == c_idle_max);
`else
    logic [31:0] w_unused_idle_cfg;
    assign w_unused_idle_cfg = 32'(IDLE_CYCLES);
`endif

endmodule
`default_nettype wire
